sixteenbit_imm_unit: RTL and testbench
======================================

SIXTEENBIT_IMM_UNIT -- requirements
Module: sixteenbit_imm_unit

Interface
REQ-001 SHALL have parameter LW_TIMEOUT, default 15: maximum number of MEM_WAIT cycles before an LW is aborted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: unit accepts a request, high only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: 00 ADDI, 01 LW, 10 SLL, 11 reserved.
REQ-007 SHALL have port a, input, 16 bits: ADDI/SLL operand A; LW base.
REQ-008 SHALL have port imm, input, 8 bits: ADDI immediate; LW offset; SLL shift amount.
REQ-009 SHALL have port mem_req, output, 1 bit: one-cycle load request pulse.
REQ-010 SHALL have port mem_addr, output, 16 bits: load address, valid while mem_req is high.
REQ-011 SHALL have port mem_rvalid, input, 1 bit: load data valid.
REQ-012 SHALL have port mem_rdata, input, 16 bits: load data.
REQ-013 SHALL have port out_valid, output, 1 bit: answer valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the answer.
REQ-015 SHALL have port answer, output, 16 bits: result.
REQ-016 SHALL have port err, output, 1 bit: reserved op or LW timeout; valid with out_valid.

Function
REQ-017 SHALL accept a request when in_valid && in_ready and register op, a and imm on that edge.
REQ-018 SHALL implement states IDLE, MEM_WAIT and RESP; ADDI, SLL and reserved ops SHALL go IDLE->RESP, and LW SHALL go IDLE->MEM_WAIT->RESP.
REQ-019 SHALL compute ADDI as answer = a + sign-extended imm, modulo 2^16 with silent wrap; out_valid SHALL rise one cycle after acceptance.
REQ-020 SHALL compute SLL as answer = a << imm, using all 8 bits of imm unsigned, with zero fill; imm >= 16 SHALL give 0; latency SHALL be 1 cycle.
REQ-021 SHALL, for LW, drive mem_addr = a + sign-extended imm (mod 2^16) and pulse mem_req for exactly the first cycle after acceptance.
REQ-022 SHALL, for LW, capture answer = mem_rdata unmodified on the first cycle mem_rvalid is high in MEM_WAIT, then enter RESP.
REQ-023 SHALL ignore mem_rvalid outside MEM_WAIT.
REQ-024 SHALL, for LW, enter RESP with answer = 0 and err = 1 if LW_TIMEOUT MEM_WAIT cycles elapse without mem_rvalid.
REQ-025 SHALL, for a reserved op, produce answer = 0 and err = 1 with 1-cycle latency.
REQ-026 SHALL hold out_valid, answer and err stable in RESP until out_ready is high, then return to IDLE on that edge.
REQ-027 SHALL keep out_valid high for exactly one cycle if out_ready is high on the first RESP cycle.
REQ-028 SHALL accept no new request in the same cycle as an out_valid/out_ready handshake; in_ready SHALL reassert on the next cycle.
REQ-029 SHALL drive err = 0 for every successful ADDI, LW and SLL.

Reset
REQ-030 SHALL, while rst_n is low, immediately force state IDLE and drive out_valid = 0, answer = 0, err = 0, mem_req = 0, mem_addr = 0 and clear the timeout counter.
REQ-031 SHALL abort any operation in flight, including MEM_WAIT, when reset asserts, with no answer produced for it.
REQ-032 SHALL drive in_ready = 1 during reset and after release.

Configuration
REQ-033 SHALL, with SIXTEENBIT_IMM_FLAGS_EN defined, add output ports zero_flag (answer == 0) and carry_flag, both registered with answer and reset to 0.
REQ-034 SHALL set carry_flag as follows: ADDI = carry out of bit 15; SLL = any 1 bit shifted out; LW and reserved = 0.
REQ-035 SHALL, with SIXTEENBIT_IMM_FLAGS_EN undefined, have neither port nor any flag logic, with all other behaviour identical.

Verification
REQ-036 ADDI a=1,imm=1 -> answer 2; a=19,imm=0xFF -> 18; a=1,imm=0 -> 1; each with err=0 and out_valid one cycle after acceptance.
REQ-037 SLL a=15,imm=2 -> 60; a=10,imm=0 -> 10; a=1,imm=15 -> 32768; a=1,imm=16 -> 0.
REQ-038 LW a=20,imm=2 -> mem_addr 22, mem_rdata 0x1234 -> answer 0x1234; a=10,imm=0xFE -> mem_addr 8; a=12345,imm=5 -> mem_addr 12350, rdata 0x9ABC -> answer 0x9ABC.
REQ-039 LW with mem_rvalid never asserted -> out_valid with answer 0, err 1 after LW_TIMEOUT wait cycles; op=11 -> answer 0, err 1.
REQ-040 out_ready held low 5 cycles in RESP -> answer stable, in_ready low; rst_n pulsed low during MEM_WAIT -> IDLE, out_valid 0, no answer.
REQ-041 With SIXTEENBIT_IMM_FLAGS_EN: ADDI a=0xFFFF,imm=1 -> answer 0, zero_flag 1, carry_flag 1.

Source files
------------

// File: rtl/sixteenbit_imm_unit.sv
`default_nettype none
// ============================================================================
// Module      : sixteenbit_imm_unit
// Description : Immediate-operand unit (ADDI / LW / SLL) with a single
//               outstanding request, a load port with timeout, and a held
//               response. Optional zero/carry flags via SIXTEENBIT_IMM_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sixteenbit_imm_unit #(
    parameter int LW_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [7:0]  imm,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] answer,
    output logic        err
`ifdef SIXTEENBIT_IMM_FLAGS_EN
    ,
    output logic        zero_flag,
    output logic        carry_flag
`endif
);

    localparam int CNT_W = (LW_TIMEOUT < 2) ? 1 : $clog2(LW_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LW_TIMEOUT - 1);

    localparam logic [1:0] c_op_addi = 2'b00;
    localparam logic [1:0] c_op_lw   = 2'b01;
    localparam logic [1:0] c_op_sll  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       answer_q, answer_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [15:0]       w_imm_sext;
    logic [15:0]       w_sum;
    logic [15:0]       w_shl;

    assign w_imm_sext = {{8{imm[7]}}, imm};
    assign w_sum      = a + w_imm_sext;
    // All 8 shift bits count: anything of 16 or more clears the result.
    assign w_shl      = (imm >= 8'd16) ? 16'd0 : (a << imm[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            answer_q   <= 16'd0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            answer_q   <= answer_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        answer_d   = answer_q;
        err_d      = err_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op)
                        c_op_addi: begin
                            answer_d = w_sum;
                            err_d    = 1'b0;
                            state_d  = ST_RESP;
                        end
                        c_op_lw: begin
                            mem_addr_d = w_sum;
                            mem_req_d  = 1'b1;
                            cnt_d      = '0;
                            state_d    = ST_MEM_WAIT;
                        end
                        c_op_sll: begin
                            answer_d = w_shl;
                            err_d    = 1'b0;
                            state_d  = ST_RESP;
                        end
                        default: begin
                            answer_d = 16'd0;
                            err_d    = 1'b1;
                            state_d  = ST_RESP;
                        end
                    endcase
                end
            end
            ST_MEM_WAIT: begin
                // Data arriving on the final allowed cycle still wins over the timeout.
                if (mem_rvalid) begin
                    answer_d = mem_rdata;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == c_cnt_last) begin
                    answer_d = 16'd0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign answer    = answer_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

`ifdef SIXTEENBIT_IMM_FLAGS_EN
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic        w_load;
    logic        w_add_carry;
    logic        w_sll_carry;
    logic [4:0]  w_sll_rshift;

    assign w_add_carry  = (a[15] & w_imm_sext[15]) |
                          ((a[15] | w_imm_sext[15]) & ~w_sum[15]);
    // Bits pushed out are the top imm bits of a; a shift of 16 on a 16-bit value yields 0.
    assign w_sll_rshift = 5'd16 - {1'b0, imm[3:0]};
    assign w_sll_carry  = (imm >= 8'd16) ? (|a) : (|(a >> w_sll_rshift));

    assign w_load = (state_q != ST_RESP) && (state_d == ST_RESP);

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (w_load) begin
            zero_d  = (answer_d == 16'd0);
            carry_d = 1'b0;
            if (state_q == ST_IDLE && op == c_op_addi) begin
                carry_d = w_add_carry;
            end else if (state_q == ST_IDLE && op == c_op_sll) begin
                carry_d = w_sll_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sixteenbit_imm_unit.sv
`default_nettype none
// Bench for sixteenbit_imm_unit: directed vectors, arithmetic reference model and
// a scoreboard compared every cycle the answer is valid.
module tb_sixteenbit_imm_unit;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [7:0]  imm;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] answer;
    logic        err;
`ifdef SIXTEENBIT_IMM_FLAGS_EN
    logic        zero_flag;
    logic        carry_flag;
`endif

    always #5 clk = ~clk;

    sixteenbit_imm_unit #(.LW_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .imm        (imm),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .answer     (answer),
        .err        (err)
`ifdef SIXTEENBIT_IMM_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    typedef struct {
        logic [15:0] ans;
        logic        err;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", nm, act, expv);
        end
    endtask

    function automatic int sext8(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    function automatic logic [15:0] model_addr(input logic [15:0] aa, input logic [7:0] ii);
        int s;
        s = ((int'(aa) + sext8(ii)) % 65536 + 65536) % 65536;
        return 16'(s);
    endfunction

    // rvd: cycle index (0 = mem_req cycle) on which rvalid is presented; <0 = never.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] aa,
                                   input logic [7:0] ii, input logic [15:0] rd, input int rvd);
        exp_t   e;
        longint s;
        int     ue;
        e.ans = 16'd0; e.err = 1'b0; e.c = 1'b0; e.z = 1'b0;
        case (o)
            2'b00: begin
                e.ans = model_addr(aa, ii);
                ue    = (sext8(ii) < 0) ? sext8(ii) + 65536 : sext8(ii);
                e.c   = (longint'(aa) + longint'(ue)) >= 65536;
            end
            2'b01: begin
                if (rvd < 0 || rvd >= T) e.err = 1'b1;
                else                     e.ans = rd;
            end
            2'b10: begin
                if (ii >= 8'd16) begin
                    e.c = (aa != 16'd0);
                end else begin
                    s     = longint'(aa) * (longint'(1) << ii);
                    e.ans = 16'(s % 65536);
                    e.c   = s >= 65536;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.z = (e.ans == 16'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                check("sb_answer", {16'd0, answer}, {16'd0, q[0].ans});
                check("sb_err", {31'd0, err}, {31'd0, q[0].err});
`ifdef SIXTEENBIT_IMM_FLAGS_EN
                check("sb_zero", {31'd0, zero_flag}, {31'd0, q[0].z});
                check("sb_carry", {31'd0, carry_flag}, {31'd0, q[0].c});
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic run(input string nm, input logic [1:0] o, input logic [15:0] aa,
                       input logic [7:0] ii, input logic [15:0] rd, input int rvd,
                       input int hold, input logic [15:0] exp_addr,
                       input logic [15:0] exp_ans, input logic exp_err, input int exp_lat);
        int lat;
        check({nm, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        q.push_back(model(o, aa, ii, rd, rvd));
        op = o; a = aa; imm = ii; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = 16'($urandom); imm = 8'($urandom);
        lat = 1;
        while (lat <= 100) begin
            if (lat == 1 && o == 2'b01) begin
                check({nm, "/mem_req"}, {31'd0, mem_req}, 32'd1);
                check({nm, "/mem_addr_model"}, {16'd0, mem_addr}, {16'd0, model_addr(aa, ii)});
                check({nm, "/mem_addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
            end else if (lat <= 2) begin
                check({nm, "/mem_req_low"}, {31'd0, mem_req}, 32'd0);
            end
            if (out_valid) break;
            if (o == 2'b01 && rvd == lat - 1) begin
                mem_rvalid = 1'b1; mem_rdata = rd;
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
            lat++;
        end
        check({nm, "/latency"}, lat, exp_lat);
        check({nm, "/answer"}, {16'd0, answer}, {16'd0, exp_ans});
        check({nm, "/err"}, {31'd0, err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            check({nm, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({nm, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "/one_cycle_valid"}, {31'd0, out_valid}, 32'd0);
        check({nm, "/in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; a = 16'd0; imm = 8'd0;
        mem_rvalid = 1'b0; mem_rdata = 16'd0; out_ready = 1'b0;
        #1;
        check("rst/in_ready", {31'd0, in_ready}, 32'd1);
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/answer", {16'd0, answer}, 32'd0);
        check("rst/err", {31'd0, err}, 32'd0);
        check("rst/mem_req", {31'd0, mem_req}, 32'd0);
        check("rst/mem_addr", {16'd0, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst/in_ready", {31'd0, in_ready}, 32'd1);

        //   name        op     a         imm    rdata     rvd  hold addr      answer    err  lat
        run("addi_1_1",  2'b00, 16'd1,    8'd1,  16'd0,    0,   0,   16'd0,    16'd2,    0,   1);
        run("addi_19_ff",2'b00, 16'd19,   8'hFF, 16'd0,    0,   0,   16'd0,    16'd18,   0,   1);
        run("addi_1_0",  2'b00, 16'd1,    8'd0,  16'd0,    0,   0,   16'd0,    16'd1,    0,   1);
        run("addi_wrap", 2'b00, 16'hFFFF, 8'd1,  16'd0,    0,   0,   16'd0,    16'd0,    0,   1);
`ifdef SIXTEENBIT_IMM_FLAGS_EN
        check("flags/zero", {31'd0, zero_flag}, 32'd1);
        check("flags/carry", {31'd0, carry_flag}, 32'd1);
`endif
        run("addi_neg",  2'b00, 16'h7FFF, 8'h80, 16'd0,    0,   0,   16'd0,    16'h7F7F, 0,   1);
        run("sll_15_2",  2'b10, 16'd15,   8'd2,  16'd0,    0,   0,   16'd0,    16'd60,   0,   1);
        run("sll_10_0",  2'b10, 16'd10,   8'd0,  16'd0,    0,   0,   16'd0,    16'd10,   0,   1);
        run("sll_1_15",  2'b10, 16'd1,    8'd15, 16'd0,    0,   0,   16'd0,    16'd32768,0,   1);
        run("sll_1_16",  2'b10, 16'd1,    8'd16, 16'd0,    0,   0,   16'd0,    16'd0,    0,   1);
        run("sll_big",   2'b10, 16'hABCD, 8'd200,16'd0,    0,   0,   16'd0,    16'd0,    0,   1);
        run("sll_out",   2'b10, 16'h8001, 8'd1,  16'd0,    0,   0,   16'd0,    16'h0002, 0,   1);
        run("lw_20_2",   2'b01, 16'd20,   8'd2,  16'h1234, 2,   0,   16'd22,   16'h1234, 0,   4);
        run("lw_10_fe",  2'b01, 16'd10,   8'hFE, 16'h5555, 0,   0,   16'd8,    16'h5555, 0,   2);
        run("lw_12345",  2'b01, 16'd12345,8'd5,  16'h9ABC, 4,   0,   16'd12350,16'h9ABC, 0,   6);
        run("lw_last",   2'b01, 16'd7,    8'd0,  16'hBEEF, T-1, 0,   16'd7,    16'hBEEF, 0,   T+1);
        run("lw_timeout",2'b01, 16'd3,    8'd4,  16'h7777, -1,  0,   16'd7,    16'd0,    1,   T+1);
        run("reserved",  2'b11, 16'd99,   8'd7,  16'd0,    0,   0,   16'd0,    16'd0,    1,   1);

        // Stray load data while idle must not produce an answer.
        mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        check("idle_rvalid/out_valid", {31'd0, out_valid}, 32'd0);

        run("hold5",     2'b00, 16'd100,  8'd5,  16'd0,    0,   5,   16'd0,    16'd105,  0,   1);
        run("lw_hold",   2'b01, 16'd40,   8'd0,  16'h0F0F, 1,   3,   16'd40,   16'h0F0F, 0,   3);

        // Reset during MEM_WAIT aborts the load.
        q.push_back(model(2'b01, 16'd100, 8'd0, 16'd0, -1));
        op = 2'b01; a = 16'd100; imm = 8'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort/in_mem_wait", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        q.delete();
        check("abort/out_valid", {31'd0, out_valid}, 32'd0);
        check("abort/in_ready", {31'd0, in_ready}, 32'd1);
        check("abort/mem_req", {31'd0, mem_req}, 32'd0);
        check("abort/mem_addr", {16'd0, mem_addr}, 32'd0);
        check("abort/answer", {16'd0, answer}, 32'd0);
        check("abort/err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < T + 4; i++) begin
            mem_rvalid = (i == 2);
            @(posedge clk); #1;
            check("abort/no_answer", {31'd0, out_valid}, 32'd0);
        end
        mem_rvalid = 1'b0;
        check("abort/in_ready_after", {31'd0, in_ready}, 32'd1);
        run("after_abort", 2'b00, 16'd5, 8'd3, 16'd0, 0, 0, 16'd0, 16'd8, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
